// File: rtl/syscall_console.sv
// Syscall/console unit: decodes halt/dec/char/hex requests, renders ASCII into a FWFT byte FIFO,
// holds the core off (o_run=0) while rendering; generator stalls on a full FIFO without losing chars.

module syscall_console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       push_vld,
  input  logic [7:0] push_dat,
  output logic       full,
  output logic [7:0] pop_dat,
  output logic       pop_vld,
  input  logic       pop_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop_vld = (cnt != '0);
  assign pop_dat = mem[rd_ptr];
  assign do_push = push_vld & ~full;
  assign do_pop  = pop_vld & pop_rdy;

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module syscall_console #(
  parameter int FIFO_DEPTH = 16,
  parameter int SIGNED_DEC = 1,
  parameter int HALT_DRAIN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sys,
  input  logic [31:0] i_num,
  input  logic [31:0] i_op1,
  input  logic        i_run,
  output logic        o_run,
  output logic        o_ack,
  output logic        o_bad,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_halt,
  output logic [7:0]  o_halt_code
);
  typedef enum logic [2:0] {IDLE, CHAR, DEC, HEX, HALT_WAIT, HALTED} state_t;

  state_t      state_q;
  logic [31:0] op_q;
  logic [31:0] mag_q;
  logic        neg_q;
  logic [3:0]  idx_q;
  logic [3:0]  dig_q;
  logic        started_q;
  logic        push_vld;
  logic [7:0]  push_dat;
  logic        fifo_full;
  logic        dec_ge;
  logic        dec_emit;
  logic        op_neg;

  function automatic logic [31:0] pow10(input logic [3:0] i);
    case (i)
      4'd0:    return 32'd1000000000;
      4'd1:    return 32'd100000000;
      4'd2:    return 32'd10000000;
      4'd3:    return 32'd1000000;
      4'd4:    return 32'd100000;
      4'd5:    return 32'd10000;
      4'd6:    return 32'd1000;
      4'd7:    return 32'd100;
      4'd8:    return 32'd10;
      default: return 32'd1;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  assign op_neg   = (SIGNED_DEC != 0) && i_op1[31];
  assign dec_ge   = (mag_q >= pow10(idx_q));
  // Leading zeros are skipped until the first nonzero digit; the units digit always prints.
  assign dec_emit = (dig_q != 4'd0) || started_q || (idx_q == 4'd9);

  always_comb begin
    push_vld = 1'b0;
    push_dat = 8'h00;
    case (state_q)
      CHAR: begin
        push_vld = 1'b1;
        push_dat = op_q[7:0];
      end
      DEC: begin
        if (neg_q) begin
          push_vld = 1'b1;
          push_dat = 8'h2D;
        end else if (!dec_ge && dec_emit) begin
          push_vld = 1'b1;
          push_dat = 8'h30 + {4'h0, dig_q};
        end
      end
      HEX: begin
        push_vld = 1'b1;
        push_dat = hex_char(op_q[31:28]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      o_run       <= 1'b0;
      o_ack       <= 1'b0;
      o_bad       <= 1'b0;
      o_halt      <= 1'b0;
      o_halt_code <= 8'h00;
      op_q        <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      idx_q       <= '0;
      dig_q       <= '0;
      started_q   <= 1'b0;
    end else begin
      o_ack <= 1'b0;
      o_bad <= 1'b0;
      o_run <= 1'b0;
      case (state_q)
        IDLE: begin
          o_run <= i_run;
          if (i_sys && !o_ack) begin
            op_q      <= i_op1;
            mag_q     <= op_neg ? -i_op1 : i_op1;
            neg_q     <= op_neg;
            idx_q     <= '0;
            dig_q     <= '0;
            started_q <= 1'b0;
            case (i_num)
              32'd0: begin
                o_run <= 1'b0;
                if (HALT_DRAIN != 0) begin
                  state_q <= HALT_WAIT;
                end else begin
                  o_halt      <= 1'b1;
                  o_halt_code <= i_op1[7:0];
                  o_ack       <= 1'b1;
                  state_q     <= HALTED;
                end
              end
              32'd2: begin state_q <= DEC;  o_run <= 1'b0; end
              32'd3: begin state_q <= CHAR; o_run <= 1'b0; end
              32'd4: begin state_q <= HEX;  o_run <= 1'b0; end
              default: begin
                o_ack <= 1'b1;
                o_bad <= 1'b1;
              end
            endcase
          end
        end
        CHAR: begin
          if (!fifo_full) begin
            o_ack   <= 1'b1;
            o_run   <= i_run;
            state_q <= IDLE;
          end
        end
        DEC: begin
          if (neg_q) begin
            if (!fifo_full) neg_q <= 1'b0;
          end else if (dec_ge) begin
            mag_q <= mag_q - pow10(idx_q);
            dig_q <= dig_q + 4'd1;
          end else if (dec_emit) begin
            if (!fifo_full) begin
              started_q <= 1'b1;
              dig_q     <= '0;
              if (idx_q == 4'd9) begin
                o_ack   <= 1'b1;
                o_run   <= i_run;
                state_q <= IDLE;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        HEX: begin
          if (!fifo_full) begin
            op_q  <= {op_q[27:0], 4'h0};
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd7) begin
              o_ack   <= 1'b1;
              o_run   <= i_run;
              state_q <= IDLE;
            end
          end
        end
        HALT_WAIT: begin
          if (!o_tx_valid) begin
            o_halt      <= 1'b1;
            o_halt_code <= op_q[7:0];
            o_ack       <= 1'b1;
            state_q     <= HALTED;
          end
        end
        HALTED: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  syscall_console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .full     (fifo_full),
    .pop_dat  (o_tx_data),
    .pop_vld  (o_tx_valid),
    .pop_rdy  (i_tx_ready)
  );
endmodule

// File: tb/tb_syscall_console.sv
// Directed bench: signed unit (FIFO 4) and unsigned unit (FIFO 8) share stimulus, selected by sel.
module tb_syscall_console;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        sys;
  logic        sel;
  logic        i_run;
  logic        tx_ready;
  logic [31:0] num;
  logic [31:0] op1;

  logic       a_sys, a_run, a_ack, a_bad, a_valid, a_halt;
  logic [7:0] a_data, a_code;
  logic       b_sys, b_run, b_ack, b_bad, b_valid, b_halt;
  logic [7:0] b_data, b_code;
  logic       m_run, m_ack, m_bad, m_valid, m_halt;
  logic [7:0] m_data, m_code;

  always #5 i_clk = ~i_clk;

  assign a_sys   = sys & ~sel;
  assign b_sys   = sys & sel;
  assign m_run   = sel ? b_run   : a_run;
  assign m_ack   = sel ? b_ack   : a_ack;
  assign m_bad   = sel ? b_bad   : a_bad;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_halt  = sel ? b_halt  : a_halt;
  assign m_data  = sel ? b_data  : a_data;
  assign m_code  = sel ? b_code  : a_code;

  syscall_console #(.FIFO_DEPTH(4), .SIGNED_DEC(1), .HALT_DRAIN(1)) u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sys(a_sys), .i_num(num), .i_op1(op1),
    .i_run(i_run), .o_run(a_run), .o_ack(a_ack), .o_bad(a_bad), .o_tx_data(a_data),
    .o_tx_valid(a_valid), .i_tx_ready(tx_ready), .o_halt(a_halt), .o_halt_code(a_code)
  );

  syscall_console #(.FIFO_DEPTH(8), .SIGNED_DEC(0), .HALT_DRAIN(1)) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sys(b_sys), .i_num(num), .i_op1(op1),
    .i_run(i_run), .o_run(b_run), .o_ack(b_ack), .o_bad(b_bad), .o_tx_data(b_data),
    .o_tx_valid(b_valid), .i_tx_ready(tx_ready), .o_halt(b_halt), .o_halt_code(b_code)
  );

  typedef struct {
    logic [31:0] num;
    logic [31:0] op1;
    logic [95:0] exp;
    int          len;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] q[$];

  always @(posedge i_clk)
    if (i_rst_n && m_valid && tx_ready) q.push_back(m_data);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [31:0] n, input logic [31:0] v, input string s);
    vec_t r;
    r.num = n;
    r.op1 = v;
    r.exp = '0;
    r.len = s.len();
    for (int i = 0; i < s.len(); i++) r.exp = {r.exp[87:0], s[i]};
    return r;
  endfunction

  function automatic string to_str(input logic [95:0] e, input int len);
    string s = "";
    for (int i = 0; i < len; i++) s = {s, $sformatf("%c", e[8*(len-1-i) +: 8])};
    return s;
  endfunction

  function automatic string q_str();
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%c", q[i])};
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic issue(input logic [31:0] n, input logic [31:0] v, input int budget,
                       output bit acked, output bit bad);
    num   = n;
    op1   = v;
    sys   = 1'b1;
    acked = 1'b0;
    bad   = 1'b0;
    for (int c = 0; c < budget && !acked; c++) begin
      @(negedge i_clk);
      if (m_ack) begin
        acked = 1'b1;
        bad   = m_bad;
      end
    end
    sys = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && m_valid; c++) @(negedge i_clk);
    chk("drain_empty", m_valid, 1'b0);
  endtask

  initial begin
    vec_t vec[12];
    bit   acked, bad, seen_ack, seen_halt;
    int   size_at_halt;

    vec[0]  = mk(32'd3, 32'h0000_0041, "A");
    vec[1]  = mk(32'd2, 32'd0,         "0");
    vec[2]  = mk(32'd2, 32'd1234,      "1234");
    vec[3]  = mk(32'd2, 32'hFFFF_FFFB, "-5");
    vec[4]  = mk(32'd2, 32'h8000_0000, "-2147483648");
    vec[5]  = mk(32'd4, 32'hDEAD_BEEF, "DEADBEEF");
    vec[6]  = mk(32'd4, 32'd0,         "00000000");
    vec[7]  = mk(32'd2, 32'd10,        "10");
    vec[8]  = mk(32'd2, 32'd1000000000, "1000000000");
    vec[9]  = mk(32'd2, 32'hFFFF_FFFF, "-1");
    vec[10] = mk(32'd4, 32'h0123_ABCD, "0123ABCD");
    vec[11] = mk(32'd3, 32'hFFFF_FF7E, "~");

    i_rst_n  = 1'b0;
    sys      = 1'b0;
    sel      = 1'b0;
    i_run    = 1'b1;
    tx_ready = 1'b1;
    num      = '0;
    op1      = '0;
    tick(3);
    chk("rst_a_run",   a_run,   1'b0);
    chk("rst_a_ack",   a_ack,   1'b0);
    chk("rst_a_bad",   a_bad,   1'b0);
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_a_halt",  a_halt,  1'b0);
    chk("rst_a_code",  a_code,  8'h00);
    chk("rst_b_run",   b_run,   1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    i_rst_n = 1'b1;
    tick(2);
    chk("idle_run", a_run, 1'b1);

    foreach (vec[i]) begin
      q.delete();
      issue(vec[i].num, vec[i].op1, 400, acked, bad);
      chk($sformatf("v%0d_ack", i), acked, 1'b1);
      chk($sformatf("v%0d_bad", i), bad, 1'b0);
      chk($sformatf("v%0d_run_after_ack", i), m_run, 1'b1);
      drain(50);
      chk_str($sformatf("v%0d_stream", i), q_str(), to_str(vec[i].exp, vec[i].len));
    end

    // Unknown syscall number: ack+bad, nothing rendered.
    q.delete();
    issue(32'd7, 32'h41, 10, acked, bad);
    chk("bad_ack", acked, 1'b1);
    chk("bad_flag", bad, 1'b1);
    chk("bad_run", m_run, 1'b1);
    tick(3);
    chk("bad_no_bytes", q.size(), 0);

    // Backpressure on a 4-deep FIFO: generator stalls, then resumes in order.
    q.delete();
    tx_ready = 1'b0;
    num = 32'd2; op1 = 32'd123456; sys = 1'b1;
    seen_ack = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      if (m_ack) seen_ack = 1'b1;
    end
    chk("bp_no_ack", seen_ack, 1'b0);
    chk("bp_run_low", m_run, 1'b0);
    chk("bp_valid", m_valid, 1'b1);
    chk("bp_head", m_data, 8'h31);
    chk("bp_no_pop", q.size(), 0);
    tx_ready = 1'b1;
    for (int c = 0; c < 100 && !seen_ack; c++) begin
      @(negedge i_clk);
      if (m_ack) seen_ack = 1'b1;
    end
    sys = 1'b0;
    chk("bp_ack", seen_ack, 1'b1);
    drain(50);
    chk_str("bp_stream", q_str(), "123456");

    // Unsigned unit.
    sel = 1'b1;
    tick(1);
    q.delete();
    issue(32'd2, 32'hFFFF_FFFB, 400, acked, bad);
    chk("uns_ack", acked, 1'b1);
    drain(50);
    chk_str("uns_stream", q_str(), "4294967291");

    // Halt waits for five queued bytes to drain.
    q.delete();
    tx_ready = 1'b0;
    issue(32'd2, 32'd12345, 200, acked, bad);
    chk("hq_ack", acked, 1'b1);
    num = 32'd0; op1 = 32'h0000_0103; sys = 1'b1;
    seen_ack = 1'b0; seen_halt = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (m_ack)  seen_ack  = 1'b1;
      if (m_halt) seen_halt = 1'b1;
    end
    chk("halt_wait_no_ack", seen_ack, 1'b0);
    chk("halt_wait_no_halt", seen_halt, 1'b0);
    chk("halt_wait_run", m_run, 1'b0);
    tx_ready = 1'b1;
    size_at_halt = -1;
    for (int c = 0; c < 50 && !seen_halt; c++) begin
      @(negedge i_clk);
      if (m_halt) begin
        seen_halt    = 1'b1;
        seen_ack     = m_ack;
        size_at_halt = q.size();
      end
    end
    sys = 1'b0;
    chk("halt_set", seen_halt, 1'b1);
    chk("halt_ack", seen_ack, 1'b1);
    chk("halt_after_5th", size_at_halt, 5);
    chk("halt_code", m_code, 8'h03);
    chk_str("halt_stream", q_str(), "12345");
    issue(32'd3, 32'h41, 10, acked, bad);
    chk("halted_no_ack", acked, 1'b0);
    chk("halted_run", m_run, 1'b0);
    tick(3);
    chk("halted_no_bytes", q.size(), 5);
    chk("halted_sticky", m_halt, 1'b1);

    // Reset in the middle of a stalled decimal render.
    sel = 1'b0;
    tick(1);
    q.delete();
    tx_ready = 1'b0;
    num = 32'd2; op1 = 32'd123456; sys = 1'b1;
    tick(20);
    chk("mid_valid_pre", m_valid, 1'b1);
    i_rst_n = 1'b0;
    sys = 1'b0;
    tick(1);
    chk("mid_rst_valid", a_valid, 1'b0);
    chk("mid_rst_run", a_run, 1'b0);
    chk("mid_rst_halt", a_halt, 1'b0);
    chk("mid_rst_b_halt", b_halt, 1'b0);
    i_rst_n = 1'b1;
    tx_ready = 1'b1;
    tick(2);
    q.delete();
    issue(32'd3, 32'h5A, 10, acked, bad);
    chk("post_rst_ack", acked, 1'b1);
    drain(20);
    chk_str("post_rst_stream", q_str(), "Z");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
